uart_buffered: RTL and testbench

- Memory-mapped serial port, successor to the fixed-rate UART.
- Adds a runtime-programmable baud divisor, parametrised TX and RX FIFOs, and configurable data and stop bits.
- Adds sticky RX-overflow, TX-overflow and frame-error flags, plus a level interrupt.
- Sits on the same io_* bus as the other peripherals; one instance per serial channel.

---
 rtl/uart_pkg.sv | 33 +++
 rtl/uart_sync_fifo.sv | 47 ++++
 rtl/uart_buffered.sv | 252 +++++++++++++++++++++++++
 tb/tb_uart_buffered.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants and state encodings for the buffered UART.
package uart_pkg;

  localparam logic [31:0] OFF_STATUS  = 32'h00;
  localparam logic [31:0] OFF_RX_DATA = 32'h04;
  localparam logic [31:0] OFF_TX_DATA = 32'h08;
  localparam logic [31:0] OFF_DIVISOR = 32'h0C;
  localparam logic [31:0] OFF_INT_EN  = 32'h10;

  localparam int unsigned ST_TX_NOT_FULL  = 0;
  localparam int unsigned ST_RX_NOT_EMPTY = 1;
  localparam int unsigned ST_RX_OVERFLOW  = 2;
  localparam int unsigned ST_FRAME_ERROR  = 3;
  localparam int unsigned ST_TX_IDLE      = 4;
  localparam int unsigned ST_TX_OVERFLOW  = 5;

  localparam int unsigned TICKS_PER_BIT = 8;

  typedef logic [1:0] tx_state_t;
  localparam tx_state_t TX_IDLE  = 2'd0;
  localparam tx_state_t TX_START = 2'd1;
  localparam tx_state_t TX_DATA  = 2'd2;
  localparam tx_state_t TX_STOP  = 2'd3;

  // RX_WAIT holds off re-arming after a framing error until the line returns high.
  typedef logic [2:0] rx_state_t;
  localparam rx_state_t RX_IDLE  = 3'd0;
  localparam rx_state_t RX_START = 3'd1;
  localparam rx_state_t RX_DATA  = 3'd2;
  localparam rx_state_t RX_STOP  = 3'd3;
  localparam rx_state_t RX_WAIT  = 3'd4;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers; accepts a push while full if it pops in the same cycle.
module uart_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_c,
  output logic             full_c,
  output logic             empty_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_pop;
  logic             do_push;

  assign empty_c = (wptr == rptr);
  assign full_c  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop & ~empty_c;
  assign do_push = push & (~full_c | do_pop);
  assign head_c  = mem[rptr[AW-1:0]];

  // Pointer update
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + PTR_ONE;
      if (do_pop)  rptr <= rptr + PTR_ONE;
    end
  end

  // Storage array, no reset needed
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_buffered.sv
// Memory-mapped UART with programmable baud divisor, TX/RX FIFOs, sticky error flags and irq.
module uart_buffered
  import uart_pkg::*;
#(
  parameter int unsigned BASE_ADDRESS    = 0,
  parameter int unsigned DEFAULT_DIVISOR = 1,
  parameter int unsigned TX_FIFO_DEPTH   = 8,
  parameter int unsigned RX_FIFO_DEPTH   = 8,
  parameter int unsigned DATA_BITS       = 8,
  parameter int unsigned STOP_BITS       = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] io_address,
  input  logic        io_read_en,
  input  logic        io_write_en,
  input  logic [31:0] io_write_data,
  output logic [31:0] io_read_data,
  output logic        uart_tx,
  input  logic        uart_rx,
  output logic        irq
);

  localparam logic [31:0] BASE      = 32'(BASE_ADDRESS);
  localparam logic [2:0]  LAST_TICK = 3'(TICKS_PER_BIT - 1);
  localparam logic [2:0]  MID_TICK  = 3'(TICKS_PER_BIT / 2 - 1);
  localparam logic [2:0]  LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0]  LAST_STOP = 3'(STOP_BITS - 1);

  logic [15:0] divisor, baud_cnt;
  logic [1:0]  int_en;
  logic        tick_c;
  logic        rx_overflow, frame_error, tx_overflow;
  logic        sel_status, sel_rx, sel_tx, sel_div, sel_int;
  logic        status_wr_c, tx_wr_c, tx_push_c, tx_pop_c, rx_pop_c;
  logic        tx_full_c, tx_empty_c, rx_full_c, rx_empty_c, tx_idle_c;
  logic [DATA_BITS-1:0] tx_head_c, rx_head_c;

  tx_state_t            tx_state, tx_state_n;
  logic [2:0]           tx_tcnt, tx_tcnt_n, tx_bcnt, tx_bcnt_n;
  logic [DATA_BITS-1:0] tx_shift, tx_shift_n;

  rx_state_t            rx_state, rx_state_n;
  logic [2:0]           rx_tcnt, rx_tcnt_n, rx_bcnt, rx_bcnt_n;
  logic [DATA_BITS-1:0] rx_shift, rx_shift_n;
  logic                 rx_meta, rx_sync, rx_done_c, rx_bad_c;

  logic unused_wdata;
  assign unused_wdata = ^io_write_data[31:16];

  assign sel_status  = (io_address == BASE + OFF_STATUS);
  assign sel_rx      = (io_address == BASE + OFF_RX_DATA);
  assign sel_tx      = (io_address == BASE + OFF_TX_DATA);
  assign sel_div     = (io_address == BASE + OFF_DIVISOR);
  assign sel_int     = (io_address == BASE + OFF_INT_EN);
  assign status_wr_c = io_write_en & sel_status;
  assign tx_wr_c     = io_write_en & sel_tx;
  assign tx_push_c   = tx_wr_c & ~tx_full_c;
  assign rx_pop_c    = io_read_en & sel_rx & ~rx_empty_c;
  assign tx_idle_c   = tx_empty_c & (tx_state == TX_IDLE);
  assign tick_c      = (baud_cnt == 16'd0);

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(TX_FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .reset_n(reset_n), .push(tx_push_c), .push_data(io_write_data[DATA_BITS-1:0]),
    .pop(tx_pop_c), .head_c(tx_head_c), .full_c(tx_full_c), .empty_c(tx_empty_c)
  );

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(RX_FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .reset_n(reset_n), .push(rx_done_c), .push_data(rx_shift),
    .pop(rx_pop_c), .head_c(rx_head_c), .full_c(rx_full_c), .empty_c(rx_empty_c)
  );

  // Baud tick: reloads from DIVISOR only on expiry so a running tick is never cut short
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    baud_cnt <= 16'd0;
    else if (tick_c) baud_cnt <= divisor - 16'd1;
    else             baud_cnt <= baud_cnt - 16'd1;
  end

  // TX next-state: bit boundaries fall on every 8th tick; STOP chains straight into START
  always_comb begin
    tx_state_n = tx_state;
    tx_tcnt_n  = tx_tcnt;
    tx_bcnt_n  = tx_bcnt;
    tx_shift_n = tx_shift;
    tx_pop_c   = 1'b0;
    if (tick_c) begin
      tx_tcnt_n = tx_tcnt + 3'd1;
      case (tx_state)
        TX_IDLE: begin
          tx_tcnt_n = 3'd0;
          if (!tx_empty_c) begin
            tx_pop_c   = 1'b1;
            tx_shift_n = tx_head_c;
            tx_state_n = TX_START;
          end
        end
        TX_START: if (tx_tcnt == LAST_TICK) begin
          tx_state_n = TX_DATA;
          tx_bcnt_n  = 3'd0;
        end
        TX_DATA: if (tx_tcnt == LAST_TICK) begin
          if (tx_bcnt == LAST_DATA) begin
            tx_state_n = TX_STOP;
            tx_bcnt_n  = 3'd0;
          end else begin
            tx_bcnt_n  = tx_bcnt + 3'd1;
            tx_shift_n = tx_shift >> 1;
          end
        end
        TX_STOP: if (tx_tcnt == LAST_TICK) begin
          if (tx_bcnt != LAST_STOP) begin
            tx_bcnt_n = tx_bcnt + 3'd1;
          end else if (!tx_empty_c) begin
            tx_pop_c   = 1'b1;
            tx_shift_n = tx_head_c;
            tx_state_n = TX_START;
          end else begin
            tx_state_n = TX_IDLE;
          end
        end
        default: tx_state_n = TX_IDLE;
      endcase
    end
  end

  // TX state and registered serial line
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state <= TX_IDLE;
      tx_tcnt  <= 3'd0;
      tx_bcnt  <= 3'd0;
      tx_shift <= '0;
      uart_tx  <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_tcnt  <= tx_tcnt_n;
      tx_bcnt  <= tx_bcnt_n;
      tx_shift <= tx_shift_n;
      uart_tx  <= (tx_state_n == TX_DATA) ? tx_shift_n[0] : (tx_state_n != TX_START);
    end
  end

  // RX next-state: mid-bit sampling, glitch rejection on the start bit, one stop bit checked
  always_comb begin
    rx_state_n = rx_state;
    rx_tcnt_n  = rx_tcnt;
    rx_bcnt_n  = rx_bcnt;
    rx_shift_n = rx_shift;
    rx_done_c  = 1'b0;
    rx_bad_c   = 1'b0;
    case (rx_state)
      RX_IDLE: if (!rx_sync) begin
        rx_state_n = RX_START;
        rx_tcnt_n  = 3'd0;
      end
      RX_START: if (tick_c) begin
        rx_tcnt_n = rx_tcnt + 3'd1;
        if (rx_tcnt == MID_TICK) begin
          rx_tcnt_n  = 3'd0;
          rx_bcnt_n  = 3'd0;
          rx_state_n = rx_sync ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: if (tick_c) begin
        rx_tcnt_n = rx_tcnt + 3'd1;
        if (rx_tcnt == LAST_TICK) begin
          rx_shift_n = {rx_sync, rx_shift[DATA_BITS-1:1]};
          if (rx_bcnt == LAST_DATA) rx_state_n = RX_STOP;
          else                      rx_bcnt_n  = rx_bcnt + 3'd1;
        end
      end
      RX_STOP: if (tick_c) begin
        rx_tcnt_n = rx_tcnt + 3'd1;
        if (rx_tcnt == LAST_TICK) begin
          if (rx_sync) begin
            rx_done_c  = 1'b1;
            rx_state_n = RX_IDLE;
          end else begin
            rx_bad_c   = 1'b1;
            rx_state_n = RX_WAIT;
          end
        end
      end
      RX_WAIT: if (rx_sync) rx_state_n = RX_IDLE;
      default: rx_state_n = RX_IDLE;
    endcase
  end

  // RX synchronizer and state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_tcnt  <= 3'd0;
      rx_bcnt  <= 3'd0;
      rx_shift <= '0;
    end else begin
      rx_meta  <= uart_rx;
      rx_sync  <= rx_meta;
      rx_state <= rx_state_n;
      rx_tcnt  <= rx_tcnt_n;
      rx_bcnt  <= rx_bcnt_n;
      rx_shift <= rx_shift_n;
    end
  end

  // Control registers, sticky flags (hardware set beats W1C) and registered irq
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      divisor     <= 16'(DEFAULT_DIVISOR);
      int_en      <= 2'b00;
      rx_overflow <= 1'b0;
      frame_error <= 1'b0;
      tx_overflow <= 1'b0;
      irq         <= 1'b0;
    end else begin
      if (io_write_en && sel_div)
        divisor <= (io_write_data[15:0] == 16'd0) ? 16'd1 : io_write_data[15:0];
      if (io_write_en && sel_int)
        int_en <= io_write_data[1:0];
      rx_overflow <= (rx_done_c & rx_full_c & ~rx_pop_c) |
                     (rx_overflow & ~(status_wr_c & io_write_data[ST_RX_OVERFLOW]));
      frame_error <= rx_bad_c | (frame_error & ~(status_wr_c & io_write_data[ST_FRAME_ERROR]));
      tx_overflow <= (tx_wr_c & tx_full_c) |
                     (tx_overflow & ~(status_wr_c & io_write_data[ST_TX_OVERFLOW]));
      irq <= (~rx_empty_c & int_en[0]) | (tx_idle_c & int_en[1]) |
             (int_en[0] & (rx_overflow | frame_error));
    end
  end

  // Combinational read mux
  always_comb begin
    io_read_data = 32'd0;
    if (sel_status) begin
      io_read_data[ST_TX_NOT_FULL]  = ~tx_full_c;
      io_read_data[ST_RX_NOT_EMPTY] = ~rx_empty_c;
      io_read_data[ST_RX_OVERFLOW]  = rx_overflow;
      io_read_data[ST_FRAME_ERROR]  = frame_error;
      io_read_data[ST_TX_IDLE]      = tx_idle_c;
      io_read_data[ST_TX_OVERFLOW]  = tx_overflow;
    end else if (sel_rx) begin
      io_read_data[DATA_BITS-1:0] = rx_empty_c ? '0 : rx_head_c;
    end else if (sel_div) begin
      io_read_data[15:0] = divisor;
    end else if (sel_int) begin
      io_read_data[1:0] = int_en;
    end
  end

endmodule

// File: tb/tb_uart_buffered.sv
// Directed bench for uart_buffered: register table plus serial corner-case sequences.
module tb_uart_buffered;
  import uart_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] io_address = 32'd0;
  logic        io_read_en = 1'b0;
  logic        io_write_en = 1'b0;
  logic [31:0] io_write_data = 32'd0;
  logic [31:0] io_read_data;
  logic        uart_tx;
  logic        irq;
  logic        loopback = 1'b0;
  logic        rx_drive = 1'b1;
  logic        rx_line;

  int n_cmp = 0;
  int n_err = 0;

  assign rx_line = loopback ? uart_tx : rx_drive;

  always #5 clk = ~clk;

  uart_buffered dut (
    .clk(clk), .reset_n(reset_n), .io_address(io_address), .io_read_en(io_read_en),
    .io_write_en(io_write_en), .io_write_data(io_write_data), .io_read_data(io_read_data),
    .uart_tx(uart_tx), .uart_rx(rx_line), .irq(irq)
  );

  typedef struct {
    bit          do_wr;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [31:0] raddr;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    io_address = a; io_write_data = d; io_write_en = 1'b1;
    @(negedge clk);
    io_write_en = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    io_address = a; io_read_en = 1'b1;
    #1 d = io_read_data;
    @(negedge clk);
    io_read_en = 1'b0;
  endtask

  task automatic chk_rd(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    check(name, d, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Drives one frame on rx_drive, then one idle bit time
  task automatic send_frame(input logic [7:0] d, input logic stop_val, input int bit_cyc);
    rx_drive = 1'b0;
    repeat (bit_cyc) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drive = d[i];
      repeat (bit_cyc) @(negedge clk);
    end
    rx_drive = stop_val;
    repeat (bit_cyc) @(negedge clk);
    rx_drive = 1'b1;
    repeat (bit_cyc) @(negedge clk);
  endtask

  initial begin
    logic [31:0] d;
    int t;
    int w;

    vecs[0]  = '{1'b0, 32'h0,  32'h0,         OFF_STATUS,  32'h11};
    vecs[1]  = '{1'b0, 32'h0,  32'h0,         OFF_RX_DATA, 32'h0};
    vecs[2]  = '{1'b1, OFF_DIVISOR, 32'h1234, OFF_DIVISOR, 32'h1234};
    vecs[3]  = '{1'b1, OFF_DIVISOR, 32'h0,    OFF_DIVISOR, 32'h1};
    vecs[4]  = '{1'b1, OFF_DIVISOR, 32'hABCD5678, OFF_DIVISOR, 32'h5678};
    vecs[5]  = '{1'b1, OFF_INT_EN,  32'hFFFFFFFF, OFF_INT_EN,  32'h3};
    vecs[6]  = '{1'b1, OFF_INT_EN,  32'h1,    OFF_INT_EN,  32'h1};
    vecs[7]  = '{1'b1, 32'h14, 32'hDEADBEEF,  OFF_DIVISOR, 32'h5678};
    vecs[8]  = '{1'b0, 32'h0,  32'h0,         32'h14,      32'h0};
    vecs[9]  = '{1'b0, 32'h0,  32'h0,         OFF_TX_DATA, 32'h0};
    vecs[10] = '{1'b1, OFF_STATUS, 32'hFFFFFFFF, OFF_STATUS, 32'h11};

    do_reset();
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].do_wr) wr(vecs[i].waddr, vecs[i].wdata);
      rd(vecs[i].raddr, d);
      check($sformatf("vec%0d", i), d, vecs[i].exp);
    end

    // Loopback, 16 clk per bit
    do_reset();
    loopback = 1'b1;
    wr(OFF_DIVISOR, 32'd2);
    wr(OFF_TX_DATA, 32'h55);
    wr(OFF_TX_DATA, 32'hA3);
    t = 0;
    while (uart_tx !== 1'b0 && t < 200) begin @(negedge clk); t++; end
    while (uart_tx !== 1'b1 && t < 200) begin @(negedge clk); t++; end
    check("lb_edge_found", 32'(t < 200), 32'd1);
    w = 0;
    while (uart_tx === 1'b1 && w < 100) begin @(negedge clk); w++; end
    check("lb_bit_len", 32'(w), 32'd16);
    repeat (400) @(negedge clk);
    chk_rd("lb_status", OFF_STATUS, 32'h13);
    chk_rd("lb_rx0", OFF_RX_DATA, 32'h55);
    chk_rd("lb_rx1", OFF_RX_DATA, 32'hA3);
    chk_rd("lb_rx_empty", OFF_RX_DATA, 32'h0);
    chk_rd("lb_status_end", OFF_STATUS, 32'h11);
    loopback = 1'b0;

    // TX overflow with the line stalled by a huge divisor
    do_reset();
    wr(OFF_DIVISOR, 32'hFFFF);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 9; i++) wr(OFF_TX_DATA, 32'(i + 1));
    chk_rd("txovf_status", OFF_STATUS, 32'h20);
    wr(OFF_STATUS, 32'h20);
    chk_rd("txovf_clear", OFF_STATUS, 32'h00);

    // RX overflow: 9 frames, no reads
    do_reset();
    wr(OFF_DIVISOR, 32'd2);
    for (int i = 0; i < 9; i++) send_frame(8'(8'h10 + i), 1'b1, 16);
    chk_rd("rxovf_status", OFF_STATUS, 32'h17);
    for (int i = 0; i < 8; i++) chk_rd($sformatf("rxovf_data%0d", i), OFF_RX_DATA, 32'(8'h10 + i));
    chk_rd("rxovf_drained", OFF_STATUS, 32'h15);
    wr(OFF_STATUS, 32'h04);
    chk_rd("rxovf_clear", OFF_STATUS, 32'h11);

    // Frame error then a good frame
    do_reset();
    wr(OFF_DIVISOR, 32'd2);
    send_frame(8'h81, 1'b0, 16);
    chk_rd("ferr_status", OFF_STATUS, 32'h19);
    send_frame(8'h3C, 1'b1, 16);
    chk_rd("ferr_next_status", OFF_STATUS, 32'h1B);
    chk_rd("ferr_next_data", OFF_RX_DATA, 32'h3C);
    wr(OFF_STATUS, 32'h08);
    chk_rd("ferr_clear", OFF_STATUS, 32'h11);

    // 2-tick glitch must not start a frame
    do_reset();
    wr(OFF_DIVISOR, 32'd2);
    rx_drive = 1'b0;
    repeat (4) @(negedge clk);
    rx_drive = 1'b1;
    repeat (100) @(negedge clk);
    chk_rd("glitch_status", OFF_STATUS, 32'h11);
    chk_rd("glitch_rx", OFF_RX_DATA, 32'h0);

    // Reset mid-frame: uart_tx returns high immediately
    do_reset();
    wr(OFF_TX_DATA, 32'h00);
    repeat (30) @(negedge clk);
    check("rst_pre_tx", 32'(uart_tx), 32'd0);
    reset_n = 1'b0;
    #1 check("rst_async_tx", 32'(uart_tx), 32'd1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    chk_rd("rst_status", OFF_STATUS, 32'h11);
    chk_rd("rst_divisor", OFF_DIVISOR, 32'd1);
    wr(OFF_INT_EN, 32'h2);
    check("irq_before", 32'(irq), 32'd0);
    @(negedge clk);
    check("irq_after", 32'(irq), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
